// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// It does one shift-add or restoring shift-subtract step per cycle, then one sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdstartE,
    input  logic [1:0]       mdopE,
    input  logic [1:0]       hilowriteE,
    input  logic             hiloselE,
    input  logic             stallE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             mdrunE,
    output logic [WIDTH-1:0] hilooutE
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op;
    logic               sa, sb, b_zero;
    logic [WIDTH-1:0]   hi, lo, mag_a, mag_b, rem;
    logic [2*WIDTH-1:0] prod;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] mul_next, prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Only the signed ops (funct[0] == 0) take magnitudes of negative operands.
    assign a_neg    = ~mdopE[0] & srcaE[WIDTH-1];
    assign b_neg    = ~mdopE[0] & srcbE[WIDTH-1];
    assign in_mag_a = a_neg ? -srcaE : srcaE;
    assign in_mag_b = b_neg ? -srcbE : srcbE;

    // Multiply: the low half starts as the multiplier and is consumed LSB-first.
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mag_a : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, prod[WIDTH-1:1]};

    // Divide: prod[WIDTH-1:0] shifts the dividend out MSB-first and the quotient in.
    assign div_shift = {rem, prod[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_ok    = ~div_diff[WIDTH];
    assign prod_neg  = -prod;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (!op[1]) begin
            if (sa ^ sb) begin
                fix_hi = prod_neg[2*WIDTH-1:WIDTH];
                fix_lo = prod_neg[WIDTH-1:0];
            end
        end else begin
            // A zero divisor leaves the all-ones quotient untouched.
            fix_lo = ((sa ^ sb) & ~b_zero) ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
            fix_hi = sa ? -rem : rem;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mdrunE <= 1'b0;
            cnt    <= '0;
            op     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            b_zero <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            rem    <= '0;
            prod   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdstartE && !stallE) begin
                        state  <= RUN;
                        mdrunE <= 1'b1;
                        op     <= mdopE;
                        sa     <= a_neg;
                        sb     <= b_neg;
                        b_zero <= (srcbE == '0);
                        mag_a  <= in_mag_a;
                        mag_b  <= in_mag_b;
                        rem    <= '0;
                        prod   <= {{WIDTH{1'b0}}, (mdopE[1] ? in_mag_a : in_mag_b)};
                        cnt    <= CW'(WIDTH - 1);
                    end else if (!stallE) begin
                        if (hilowriteE[1]) hi <= srcaE;
                        if (hilowriteE[0]) lo <= srcaE;
                    end
                end
                RUN: begin
                    if (op[1]) begin
                        prod <= {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], div_ok};
                        rem  <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    end else begin
                        prod <= mul_next;
                    end
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    hi     <= fix_hi;
                    lo     <= fix_lo;
                    state  <= IDLE;
                    mdrunE <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    mdrunE <= 1'b0;
                end
            endcase
        end
    end

    assign hilooutE = hiloselE ? hi : lo;

endmodule
